// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// One quotient bit per clock; result {Q,R} is registered on entry to DONE.
module exe_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  div_start,
    input  logic                  div_signed,
    input  logic [DATA_W-1:0]     div_dividend,
    input  logic [DATA_W-1:0]     div_divisor,
    input  logic                  div_cancel,
    output logic                  div_busy,
    output logic                  div_finish,
    output logic [2*DATA_W-1:0]   div_result,
    output logic [1:0]            div_state_o
);

    // Handshake: div_start is accepted only in IDLE (busy=0) without a same-cycle cancel;
    // div_finish is a single-cycle valid pulse with no ready, and a start while busy is dropped.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    dvd_q, dvd_d;
    logic [DATA_W-1:0]    dvs_q, dvs_d;
    logic [DATA_W:0]      rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 dz_q, dz_d;
    logic [2*DATA_W-1:0]  result_q, result_d;

    logic                 start_ok;
    logic                 dvd_neg, dvs_neg;
    logic [DATA_W:0]      rem_sh, diff, rem_step;
    logic                 q_bit;
    logic [DATA_W-1:0]    quo_step;
    logic [DATA_W-1:0]    q_fix, r_fix;

    assign start_ok = div_start & ~div_cancel;
    assign dvd_neg  = div_signed & div_dividend[DATA_W-1];
    assign dvs_neg  = div_signed & div_divisor[DATA_W-1];

    // dvd_q doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
    assign rem_sh   = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign q_bit    = ~diff[DATA_W];
    assign rem_step = q_bit ? diff : rem_sh;
    assign quo_step = {dvd_q[DATA_W-2:0], q_bit};

    // Divide by zero forces Q to all ones; R naturally returns the raw dividend after sign correction.
    assign q_fix = dz_q ? {DATA_W{1'b1}} : (q_neg_q ? (~quo_step + ONE_D) : quo_step);
    assign r_fix = r_neg_q ? (~rem_step[DATA_W-1:0] + ONE_D) : rem_step[DATA_W-1:0];

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_CALC;
                    dvd_d   = dvd_neg ? (~div_dividend + ONE_D) : div_dividend;
                    dvs_d   = dvs_neg ? (~div_divisor + ONE_D) : div_divisor;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    dz_d    = (div_divisor == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                dvd_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = {q_fix, r_fix};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (div_cancel) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign div_busy    = (state_q != S_IDLE);
    assign div_finish  = (state_q == S_DONE) & ~div_cancel;
    assign div_result  = result_q;
    assign div_state_o = state_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed and randomized bench for exe_div_unit: cycle-exact busy/finish timing,
// sign/overflow/zero-divisor results, cancel, ignored starts and async reset.
module tb_exe_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_cancel;
    logic        div_busy;
    logic        div_finish;
    logic [63:0] div_result;
    logic [1:0]  div_state_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] last_result = '0;
    logic [63:0] exp_q[$];

    exe_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_cancel   (div_cancel),
        .div_busy     (div_busy),
        .div_finish   (div_finish),
        .div_result   (div_result),
        .div_state_o  (div_state_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Called at a negedge (cycle 0). Returns at the negedge of the first idle cycle afterwards.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int junk_at, input int cancel_at);
        logic [63:0] prev;
        logic        cancelled;
        prev         = last_result;
        cancelled    = 1'b0;
        exp_q.push_back(exp);
        div_signed   = sgn;
        div_dividend = a;
        div_divisor  = b;
        div_start    = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), {63'd0, div_busy}, 64'd1);
            chk($sformatf("finish_c%0d", c), {63'd0, div_finish}, {63'd0, (c == 33)});
            if (c == 33) begin
                last_result = exp_q.pop_front();
                chk("result", div_result, last_result);
            end
            div_start  = 1'b0;
            div_cancel = 1'b0;
            if (c == junk_at) begin
                div_start    = 1'b1;
                div_dividend = 32'd50;
                div_divisor  = 32'd5;
            end
            if (c == cancel_at) begin
                div_cancel = 1'b1;
                cancelled  = 1'b1;
                break;
            end
        end
        if (cancelled) begin
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
            div_cancel = 1'b0;
            @(negedge clk);
            chk("cancel_busy", {63'd0, div_busy}, 64'd0);
            chk("cancel_finish", {63'd0, div_finish}, 64'd0);
            chk("cancel_result", div_result, prev);
            last_result = prev;
        end else begin
            div_start = 1'b0;
            @(negedge clk);
            chk("idle_busy", {63'd0, div_busy}, 64'd0);
            chk("idle_finish", {63'd0, div_finish}, 64'd0);
            chk("idle_result", div_result, last_result);
        end
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        int          cx;

        resetn       = 1'b0;
        div_start    = 1'b0;
        div_signed   = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        div_cancel   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, div_busy}, 64'd0);
        chk("rst_finish", {63'd0, div_finish}, 64'd0);
        chk("rst_result", div_result, 64'd0);
        chk("rst_state", {62'd0, div_state_o}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // basic unsigned, signed corner cases, divide by zero
        run_op(1'b0, 32'd100, 32'd7, 64'h0000000E_00000002, 0, 0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 0, 0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 0, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 0, 0);
        run_op(1'b0, 32'h12345678, 32'd0, 64'hFFFFFFFF_12345678, 0, 0);
        run_op(1'b1, 32'hFFFFFF00, 32'd0, 64'hFFFFFFFF_FFFFFF00, 0, 0);

        // cancel in cycle 10, then a new op starting in cycle 11
        run_op(1'b0, 32'd100, 32'd7, 64'h0000000E_00000002, 0, 10);
        run_op(1'b0, 32'd9, 32'd3, 64'h00000003_00000000, 0, 0);

        // start while busy is ignored; back-to-back start in cycle 34 accepted
        run_op(1'b0, 32'd100, 32'd7, 64'h0000000E_00000002, 5, 0);
        run_op(1'b0, 32'd1000, 32'd10, 64'h00000064_00000000, 0, 0);

        // cancel and start in the same idle cycle: start dropped
        div_dividend = 32'd77;
        div_divisor  = 32'd3;
        div_start    = 1'b1;
        div_cancel   = 1'b1;
        @(posedge clk);
        #1;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        @(negedge clk);
        chk("cs_busy", {63'd0, div_busy}, 64'd0);
        chk("cs_finish", {63'd0, div_finish}, 64'd0);
        chk("cs_result", div_result, last_result);

        // asynchronous reset mid-CALC
        div_signed   = 1'b0;
        div_dividend = 32'd100;
        div_divisor  = 32'd7;
        div_start    = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", {63'd0, div_busy}, 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_busy", {63'd0, div_busy}, 64'd0);
        chk("arst_finish", {63'd0, div_finish}, 64'd0);
        chk("arst_result", div_result, 64'd0);
        chk("arst_state", {62'd0, div_state_o}, 64'd0);
        last_result = '0;
        #1;
        resetn = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'd10, 32'd3, 64'h00000003_00000001, 0, 0);

        // randomized operations against the reference model
        for (int i = 0; i < 20; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            cx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32)) : 0;
            run_op(sgn, a, b, ref_div(sgn, a, b), 0, cx);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
